// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, instruction classes, the per-class
// operand/immediate table and the ID/EX register layout.
package decode_pkg;

   localparam int NUM_REGS = 8;
   localparam int DATA_W   = 16;
   localparam int REG_W    = 3;
   localparam int OP_W     = 5;

   localparam logic [REG_W-1:0] R7 = 3'd7;

   localparam logic [OP_W-1:0] OP_HALT  = 5'b00000;
   localparam logic [OP_W-1:0] OP_NOP   = 5'b00001;
   localparam logic [OP_W-1:0] OP_J     = 5'b00100;
   localparam logic [OP_W-1:0] OP_JR    = 5'b00101;
   localparam logic [OP_W-1:0] OP_JAL   = 5'b00110;
   localparam logic [OP_W-1:0] OP_JALR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_ADDI  = 5'b01000;
   localparam logic [OP_W-1:0] OP_SUBI  = 5'b01001;
   localparam logic [OP_W-1:0] OP_XORI  = 5'b01010;
   localparam logic [OP_W-1:0] OP_ANDNI = 5'b01011;
   localparam logic [OP_W-1:0] OP_BEQZ  = 5'b01100;
   localparam logic [OP_W-1:0] OP_BNEZ  = 5'b01101;
   localparam logic [OP_W-1:0] OP_BLTZ  = 5'b01110;
   localparam logic [OP_W-1:0] OP_BGEZ  = 5'b01111;
   localparam logic [OP_W-1:0] OP_ST    = 5'b10000;
   localparam logic [OP_W-1:0] OP_LD    = 5'b10001;
   localparam logic [OP_W-1:0] OP_SLBI  = 5'b10010;
   localparam logic [OP_W-1:0] OP_STU   = 5'b10011;
   localparam logic [OP_W-1:0] OP_ROLI  = 5'b10100;
   localparam logic [OP_W-1:0] OP_SLLI  = 5'b10101;
   localparam logic [OP_W-1:0] OP_RORI  = 5'b10110;
   localparam logic [OP_W-1:0] OP_SRLI  = 5'b10111;
   localparam logic [OP_W-1:0] OP_LBI   = 5'b11000;
   localparam logic [OP_W-1:0] OP_BTR   = 5'b11001;
   localparam logic [OP_W-1:0] OP_SHIFT = 5'b11010;
   localparam logic [OP_W-1:0] OP_ARITH = 5'b11011;
   localparam logic [OP_W-1:0] OP_SEQ   = 5'b11100;
   localparam logic [OP_W-1:0] OP_SLT   = 5'b11101;
   localparam logic [OP_W-1:0] OP_SLE   = 5'b11110;
   localparam logic [OP_W-1:0] OP_SCO   = 5'b11111;

   typedef enum logic [3:0] {
      RFMT, IFMT1, IFMT2, LOAD, STORE, STU, BRANCH, JUMP, JUMPREG, HALT, NOP
   } instrClass_e;

   typedef enum logic [2:0] {
      IMM_NONE, IMM5_S, IMM5_Z, IMM8_S, IMM8_Z, IMM11_S
   } immKind_e;

   typedef struct packed {
      logic     readsRs;
      logic     readsRt;
      logic     writes;
      immKind_e immKind;
   } classInfo_t;

   typedef struct packed {
      logic [DATA_W-1:0] rsData;
      logic [DATA_W-1:0] rtData;
      logic [DATA_W-1:0] imm;
      logic [REG_W-1:0]  wrReg;
      logic              regWrite;
      logic              memRead;
      logic              memWrite;
      logic [OP_W-1:0]   opcode;
      logic [1:0]        func;
      logic [DATA_W-1:0] pc2;
      logic              halt;
      logic              err;
   } idex_t;

   // Undefined opcodes decode as NOP; opUndefined flags them separately.
   function automatic instrClass_e opClass(input logic [OP_W-1:0] op);
      instrClass_e cls;
      case (op)
         OP_HALT:                              cls = HALT;
         OP_J, OP_JAL:                         cls = JUMP;
         OP_JR, OP_JALR:                       cls = JUMPREG;
         OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
         OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI:   cls = IFMT1;
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ:   cls = BRANCH;
         OP_ST:                                cls = STORE;
         OP_LD:                                cls = LOAD;
         OP_STU:                               cls = STU;
         OP_LBI, OP_SLBI:                      cls = IFMT2;
         OP_BTR, OP_SHIFT, OP_ARITH,
         OP_SEQ, OP_SLT, OP_SLE, OP_SCO:       cls = RFMT;
         default:                              cls = NOP;
      endcase
      return cls;
   endfunction

   function automatic logic opUndefined(input logic [OP_W-1:0] op);
      return (op == 5'b00010) || (op == 5'b00011);
   endfunction

   // Class-level defaults; SLBI, JAL/JALR and the logical/shift immediates refine these.
   function automatic classInfo_t classInfo(input instrClass_e cls);
      classInfo_t info;
      case (cls)
         RFMT:    info = '{readsRs: 1'b1, readsRt: 1'b1, writes: 1'b1, immKind: IMM_NONE};
         IFMT1:   info = '{readsRs: 1'b1, readsRt: 1'b0, writes: 1'b1, immKind: IMM5_S};
         IFMT2:   info = '{readsRs: 1'b0, readsRt: 1'b0, writes: 1'b1, immKind: IMM8_S};
         LOAD:    info = '{readsRs: 1'b1, readsRt: 1'b0, writes: 1'b1, immKind: IMM5_S};
         STORE:   info = '{readsRs: 1'b1, readsRt: 1'b1, writes: 1'b0, immKind: IMM5_S};
         STU:     info = '{readsRs: 1'b1, readsRt: 1'b1, writes: 1'b1, immKind: IMM5_S};
         BRANCH:  info = '{readsRs: 1'b1, readsRt: 1'b0, writes: 1'b0, immKind: IMM8_S};
         JUMP:    info = '{readsRs: 1'b0, readsRt: 1'b0, writes: 1'b0, immKind: IMM11_S};
         JUMPREG: info = '{readsRs: 1'b1, readsRt: 1'b0, writes: 1'b0, immKind: IMM8_S};
         default: info = '{readsRs: 1'b0, readsRt: 1'b0, writes: 1'b0, immKind: IMM_NONE};
      endcase
      return info;
   endfunction

   function automatic logic [DATA_W-1:0] extendImm(input logic [DATA_W-1:0] instr,
                                                   input immKind_e kind);
      logic [DATA_W-1:0] imm;
      case (kind)
         IMM5_S:  imm = {{11{instr[4]}}, instr[4:0]};
         IMM5_Z:  imm = {11'd0, instr[4:0]};
         IMM8_S:  imm = {{8{instr[7]}}, instr[7:0]};
         IMM8_Z:  imm = {8'd0, instr[7:0]};
         IMM11_S: imm = {{5{instr[10]}}, instr[10:0]};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_if.sv
// IF/ID inputs, pipeline feedback, WB write port and ID/EX outputs of the decode stage.
interface decode_if;
   import decode_pkg::*;

   logic [DATA_W-1:0] instr_IFID;
   logic [DATA_W-1:0] PC2_IFID;
   logic              halt_IFID;
   logic              takeBranch_EXMEM;
   logic [REG_W-1:0]  wrReg_IDEX_fb;
   logic              regWrite_EXMEM;
   logic [REG_W-1:0]  wrReg_EXMEM;
   logic              regWrite_MEMWB;
   logic [REG_W-1:0]  wrReg_MEMWB;
   logic [DATA_W-1:0] wrData_MEMWB;

   logic              stallCtrl;
   logic              Jump;
   logic [DATA_W-1:0] rsData_IDEX;
   logic [DATA_W-1:0] rtData_IDEX;
   logic [DATA_W-1:0] imm_IDEX;
   logic [REG_W-1:0]  wrReg_IDEX;
   logic              regWrite_IDEX;
   logic              memRead_IDEX;
   logic              memWrite_IDEX;
   logic [OP_W-1:0]   opcode_IDEX;
   logic [1:0]        func_IDEX;
   logic [DATA_W-1:0] PC2_IDEX;
   logic              halt_IDEX;
   logic              err;

   modport master (
      output instr_IFID, PC2_IFID, halt_IFID, takeBranch_EXMEM, wrReg_IDEX_fb,
             regWrite_EXMEM, wrReg_EXMEM, regWrite_MEMWB, wrReg_MEMWB, wrData_MEMWB,
      input  stallCtrl, Jump, rsData_IDEX, rtData_IDEX, imm_IDEX, wrReg_IDEX,
             regWrite_IDEX, memRead_IDEX, memWrite_IDEX, opcode_IDEX, func_IDEX,
             PC2_IDEX, halt_IDEX, err
   );

   modport slave (
      input  instr_IFID, PC2_IFID, halt_IFID, takeBranch_EXMEM, wrReg_IDEX_fb,
             regWrite_EXMEM, wrReg_EXMEM, regWrite_MEMWB, wrReg_MEMWB, wrData_MEMWB,
      output stallCtrl, Jump, rsData_IDEX, rtData_IDEX, imm_IDEX, wrReg_IDEX,
             regWrite_IDEX, memRead_IDEX, memWrite_IDEX, opcode_IDEX, func_IDEX,
             PC2_IDEX, halt_IDEX, err
   );

endinterface

// File: rtl/regfile_bypass.sv
// 8x16 register file, two combinational read ports and one write port.
// A read of the register being written this cycle sees the incoming data.
module regfile_bypass
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_W-1:0]  rdAddrA_i,
   input  logic [REG_W-1:0]  rdAddrB_i,
   output logic [DATA_W-1:0] rdDataA_o,
   output logic [DATA_W-1:0] rdDataB_o,
   input  logic              wrEn_i,
   input  logic [REG_W-1:0]  wrAddr_i,
   input  logic [DATA_W-1:0] wrData_i
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (wrEn_i) begin
         regs_d[wrAddr_i] = wrData_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdDataA_o = (wrEn_i && (wrAddr_i == rdAddrA_i)) ? wrData_i : regs_q[rdAddrA_i];
   assign rdDataB_o = (wrEn_i && (wrAddr_i == rdAddrB_i)) ? wrData_i : regs_q[rdAddrB_i];

endmodule

// File: rtl/decode_stage.sv
// Pipeline ID stage: field decode, register read, RAW hazard stall against EX and MEM,
// J/JAL redirect request and the ID/EX register with bubble insertion.
module decode_stage
   import decode_pkg::*;
(
   input logic     clk,
   input logic     rst,
   decode_if.slave bus
);

   logic [OP_W-1:0]   opcode;
   logic [REG_W-1:0]  rsAddr;
   logic [REG_W-1:0]  rtAddr;
   instrClass_e       cls;
   classInfo_t        info;
   logic              readsRs;
   logic              readsRt;
   logic              writesReg;
   immKind_e          immKind;
   logic [REG_W-1:0]  destReg;
   logic [DATA_W-1:0] rsData;
   logic [DATA_W-1:0] rtData;
   logic              rsHazard;
   logic              rtHazard;
   logic              stall;
   logic              squash;
   idex_t             idex_q;
   idex_t             idex_d;

   assign opcode = bus.instr_IFID[15:11];
   assign rsAddr = bus.instr_IFID[10:8];
   assign rtAddr = bus.instr_IFID[7:5];
   assign squash = bus.takeBranch_EXMEM;

   regfile_bypass u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rdAddrA_i (rsAddr),
      .rdAddrB_i (rtAddr),
      .rdDataA_o (rsData),
      .rdDataB_o (rtData),
      .wrEn_i    (bus.regWrite_MEMWB),
      .wrAddr_i  (bus.wrReg_MEMWB),
      .wrData_i  (bus.wrData_MEMWB)
   );

   // Class table gives the defaults; a few opcodes inside a class differ in reads/writes/extension.
   always_comb begin
      cls       = opClass(opcode);
      info      = classInfo(cls);
      readsRs   = info.readsRs | (opcode == OP_SLBI);
      readsRt   = info.readsRt;
      writesReg = (info.writes | (opcode == OP_JAL) | (opcode == OP_JALR)) & ~bus.halt_IFID;
      immKind   = info.immKind;
      if ((cls == IFMT1) && (opcode != OP_ADDI) && (opcode != OP_SUBI)) begin
         immKind = IMM5_Z;
      end
      if (opcode == OP_SLBI) begin
         immKind = IMM8_Z;
      end
      case (cls)
         RFMT:          destReg = bus.instr_IFID[4:2];
         IFMT1, LOAD:   destReg = rtAddr;
         IFMT2, STU:    destReg = rsAddr;
         JUMP, JUMPREG: destReg = R7;
         default:       destReg = '0;
      endcase
   end

   // Without forwarding, any producer still in EX or EX/MEM blocks the read;
   // MEM/WB producers are served by the register-file bypass instead.
   always_comb begin
      rsHazard = readsRs &&
                 ((idex_q.regWrite && (bus.wrReg_IDEX_fb == rsAddr)) ||
                  (bus.regWrite_EXMEM && (bus.wrReg_EXMEM == rsAddr)));
      rtHazard = readsRt &&
                 ((idex_q.regWrite && (bus.wrReg_IDEX_fb == rtAddr)) ||
                  (bus.regWrite_EXMEM && (bus.wrReg_EXMEM == rtAddr)));
      stall    = (rsHazard || rtHazard) && !squash && !bus.halt_IFID;
   end

   // A squashed or stalled slot becomes a NOP bubble with every other field zeroed.
   always_comb begin
      idex_d        = '0;
      idex_d.opcode = OP_NOP;
      if (!squash && !stall) begin
         idex_d.rsData   = rsData;
         idex_d.rtData   = rtData;
         idex_d.imm      = extendImm(bus.instr_IFID, immKind);
         idex_d.wrReg    = writesReg ? destReg : '0;
         idex_d.regWrite = writesReg;
         idex_d.memRead  = (cls == LOAD);
         idex_d.memWrite = (cls == STORE) || (cls == STU);
         idex_d.opcode   = opcode;
         idex_d.func     = bus.instr_IFID[1:0];
         idex_d.pc2      = bus.PC2_IFID;
         idex_d.halt     = bus.halt_IFID;
         idex_d.err      = opUndefined(opcode);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign bus.stallCtrl     = stall;
   assign bus.Jump          = ((opcode == OP_J) || (opcode == OP_JAL)) && !stall && !squash;
   assign bus.rsData_IDEX   = idex_q.rsData;
   assign bus.rtData_IDEX   = idex_q.rtData;
   assign bus.imm_IDEX      = idex_q.imm;
   assign bus.wrReg_IDEX    = idex_q.wrReg;
   assign bus.regWrite_IDEX = idex_q.regWrite;
   assign bus.memRead_IDEX  = idex_q.memRead;
   assign bus.memWrite_IDEX = idex_q.memWrite;
   assign bus.opcode_IDEX   = idex_q.opcode;
   assign bus.func_IDEX     = idex_q.func;
   assign bus.PC2_IDEX      = idex_q.pc2;
   assign bus.halt_IDEX     = idex_q.halt;
   assign bus.err           = idex_q.err;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus hand-written
// sequences for bypass, load-use stall, jump, squash, reset and halt.
module tb_decode_stage;
   import decode_pkg::*;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc2;
      logic        expStall;
      logic        expJump;
      logic [15:0] expRs;
      logic [15:0] expRt;
      logic [15:0] expImm;
      logic [2:0]  expWrReg;
      logic        expRegWrite;
      logic        expMemRead;
      logic        expMemWrite;
      logic [4:0]  expOpcode;
      logic [1:0]  expFunc;
      logic [15:0] expPc2;
      logic        expErr;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs [16];

   always #5 clk = ~clk;

   decode_if bus ();

   decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.wrReg_IDEX_fb = bus.wrReg_IDEX;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkIdex(input string tag, input logic [15:0] rs, input logic [15:0] rt,
                            input logic [15:0] imm, input logic [2:0] wr, input logic rw,
                            input logic mr, input logic mw, input logic [4:0] op,
                            input logic [1:0] fn, input logic [15:0] pc2, input logic hlt,
                            input logic er);
      checkOutput({tag, ".rs"},       bus.rsData_IDEX, rs);
      checkOutput({tag, ".rt"},       bus.rtData_IDEX, rt);
      checkOutput({tag, ".imm"},      bus.imm_IDEX, imm);
      checkOutput({tag, ".wrReg"},    16'(bus.wrReg_IDEX), 16'(wr));
      checkOutput({tag, ".regWrite"}, 16'(bus.regWrite_IDEX), 16'(rw));
      checkOutput({tag, ".memRead"},  16'(bus.memRead_IDEX), 16'(mr));
      checkOutput({tag, ".memWrite"}, 16'(bus.memWrite_IDEX), 16'(mw));
      checkOutput({tag, ".opcode"},   16'(bus.opcode_IDEX), 16'(op));
      checkOutput({tag, ".func"},     16'(bus.func_IDEX), 16'(fn));
      checkOutput({tag, ".pc2"},      bus.PC2_IDEX, pc2);
      checkOutput({tag, ".halt"},     16'(bus.halt_IDEX), 16'(hlt));
      checkOutput({tag, ".err"},      16'(bus.err), 16'(er));
   endtask

   task automatic checkComb(input string tag, input logic expStall, input logic expJump);
      checkOutput({tag, ".stall"}, 16'(bus.stallCtrl), 16'(expStall));
      checkOutput({tag, ".jump"},  16'(bus.Jump), 16'(expJump));
   endtask

   task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc2, input logic hlt);
      bus.instr_IFID = instr;
      bus.PC2_IFID   = pc2;
      bus.halt_IFID  = hlt;
   endtask

   task automatic setExMem(input logic we, input logic [2:0] rd);
      bus.regWrite_EXMEM = we;
      bus.wrReg_EXMEM    = rd;
   endtask

   task automatic setWb(input logic we, input logic [2:0] rd, input logic [15:0] data);
      bus.regWrite_MEMWB = we;
      bus.wrReg_MEMWB    = rd;
      bus.wrData_MEMWB   = data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // instr, pc2, stall, jump, rs, rt, imm, wrReg, rw, mr, mw, opcode, func, pc2 out, err
      vecs[0]  = '{16'hDAB9, 16'h0100, 1'b0, 1'b0, 16'h1222, 16'h1555, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0, 5'b11011, 2'b01, 16'h0100, 1'b0};
      vecs[1]  = '{16'h4C7E, 16'h0102, 1'b0, 1'b0, 16'h1444, 16'h1333, 16'hFFFE, 3'd3, 1'b1, 1'b0, 1'b0, 5'b01001, 2'b10, 16'h0102, 1'b0};
      vecs[2]  = '{16'h51BF, 16'h0104, 1'b0, 1'b0, 16'h1111, 16'h1555, 16'h001F, 3'd5, 1'b1, 1'b0, 1'b0, 5'b01010, 2'b11, 16'h0104, 1'b0};
      vecs[3]  = '{16'h80FF, 16'h0106, 1'b0, 1'b0, 16'h1000, 16'h1777, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b1, 5'b10000, 2'b11, 16'h0106, 1'b0};
      vecs[4]  = '{16'hC280, 16'h0108, 1'b0, 1'b0, 16'h1222, 16'h1444, 16'hFF80, 3'd2, 1'b1, 1'b0, 1'b0, 5'b11000, 2'b00, 16'h0108, 1'b0};
      vecs[5]  = '{16'h9480, 16'h010A, 1'b0, 1'b0, 16'h1444, 16'h1444, 16'h0080, 3'd4, 1'b1, 1'b0, 1'b0, 5'b10010, 2'b00, 16'h010A, 1'b0};
      vecs[6]  = '{16'h61FC, 16'h010C, 1'b0, 1'b0, 16'h1111, 16'h1777, 16'hFFFC, 3'd0, 1'b0, 1'b0, 1'b0, 5'b01100, 2'b00, 16'h010C, 1'b0};
      vecs[7]  = '{16'h3005, 16'h010E, 1'b0, 1'b1, 16'h1000, 16'h1000, 16'h0005, 3'd7, 1'b1, 1'b0, 1'b0, 5'b00110, 2'b01, 16'h010E, 1'b0};
      vecs[8]  = '{16'h3B02, 16'h0110, 1'b0, 1'b0, 16'h1333, 16'h1000, 16'h0002, 3'd7, 1'b1, 1'b0, 1'b0, 5'b00111, 2'b10, 16'h0110, 1'b0};
      vecs[9]  = '{16'h9F21, 16'h0112, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00001, 2'b00, 16'h0000, 1'b0};
      vecs[10] = '{16'h9F21, 16'h0114, 1'b0, 1'b0, 16'h1777, 16'h1111, 16'h0001, 3'd7, 1'b1, 1'b0, 1'b1, 5'b10011, 2'b01, 16'h0114, 1'b0};
      vecs[11] = '{16'h1000, 16'h0116, 1'b0, 1'b0, 16'h1000, 16'h1000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00010, 2'b00, 16'h0116, 1'b1};
      vecs[12] = '{16'h0800, 16'h0118, 1'b0, 1'b0, 16'h1000, 16'h1000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00001, 2'b00, 16'h0118, 1'b0};
      vecs[13] = '{16'h8BC3, 16'h011A, 1'b0, 1'b0, 16'h1333, 16'h1666, 16'h0003, 3'd6, 1'b1, 1'b1, 1'b0, 5'b10001, 2'b11, 16'h011A, 1'b0};
      vecs[14] = '{16'hA624, 16'h011C, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00001, 2'b00, 16'h0000, 1'b0};
      vecs[15] = '{16'hA624, 16'h011E, 1'b0, 1'b0, 16'h1666, 16'h1111, 16'h0004, 3'd1, 1'b1, 1'b0, 1'b0, 5'b10100, 2'b00, 16'h011E, 1'b0};

      rst = 1'b1;
      applyStimulus(16'h0800, 16'h0000, 1'b0);
      bus.takeBranch_EXMEM = 1'b0;
      setExMem(1'b0, 3'd0);
      setWb(1'b0, 3'd0, 16'h0000);

      // Reset state, then a NOP decodes to all-zero with opcode 00001
      repeat (2) @(posedge clk);
      #1;
      checkIdex("rst", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 16'h0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      checkComb("nop", 1'b0, 1'b0);
      tick();
      checkIdex("nop", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00001, 2'b00, 16'h0, 1'b0, 1'b0);

      // Same-cycle WB write is visible to the read
      setWb(1'b1, 3'd3, 16'hBEEF);
      applyStimulus(16'hDB64, 16'h0002, 1'b0);
      #1;
      checkComb("byp", 1'b0, 1'b0);
      tick();
      checkIdex("byp", 16'hBEEF, 16'hBEEF, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0, 5'b11011, 2'b00, 16'h0002, 1'b0, 1'b0);
      setWb(1'b0, 3'd0, 16'h0000);
      #1;
      checkOutput("stored.stall", 16'(bus.stallCtrl), 16'h0000);
      applyStimulus(16'h0800, 16'h0000, 1'b0);

      // Preload R_i = 0x1000 + i*0x111 while NOPs flow
      for (int i = 0; i < 8; i++) begin
         setWb(1'b1, 3'(i), 16'h1000 + 16'(i) * 16'h0111);
         tick();
      end
      setWb(1'b0, 3'd0, 16'h0000);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].instr, vecs[i].pc2, 1'b0);
         #1;
         checkComb($sformatf("v%0d", i), vecs[i].expStall, vecs[i].expJump);
         tick();
         checkIdex($sformatf("v%0d", i), vecs[i].expRs, vecs[i].expRt, vecs[i].expImm,
                   vecs[i].expWrReg, vecs[i].expRegWrite, vecs[i].expMemRead,
                   vecs[i].expMemWrite, vecs[i].expOpcode, vecs[i].expFunc,
                   vecs[i].expPc2, 1'b0, vecs[i].expErr);
      end

      // Load-use: LD R2 then ADDI R4,R2,#1 stalls through EX and EX/MEM
      applyStimulus(16'h8D40, 16'h0200, 1'b0);
      tick();
      checkIdex("ld", 16'h1555, 16'h1222, 16'h0, 3'd2, 1'b1, 1'b1, 1'b0, 5'b10001, 2'b00, 16'h0200, 1'b0, 1'b0);
      applyStimulus(16'h4281, 16'h0202, 1'b0);
      #1;
      checkComb("luEx", 1'b1, 1'b0);
      tick();
      checkOutput("luEx.opcode", 16'(bus.opcode_IDEX), 16'h0001);
      checkOutput("luEx.regWrite", 16'(bus.regWrite_IDEX), 16'h0000);
      setExMem(1'b1, 3'd2);
      setWb(1'b1, 3'd2, 16'h0041);
      #1;
      checkComb("luMem", 1'b1, 1'b0);
      tick();
      checkOutput("luMem.opcode", 16'(bus.opcode_IDEX), 16'h0001);
      setExMem(1'b0, 3'd0);
      setWb(1'b1, 3'd2, 16'h0042);
      #1;
      checkComb("luWb", 1'b0, 1'b0);
      tick();
      checkIdex("luWb", 16'h0042, 16'h1444, 16'h0001, 3'd4, 1'b1, 1'b0, 1'b0, 5'b01000, 2'b01, 16'h0202, 1'b0, 1'b0);
      setWb(1'b0, 3'd0, 16'h0000);
      applyStimulus(16'h0800, 16'h0204, 1'b0);
      tick();

      // J with negative displacement
      applyStimulus(16'h27FE, 16'h0010, 1'b0);
      #1;
      checkComb("jmp", 1'b0, 1'b1);
      tick();
      checkOutput("jmp.imm", bus.imm_IDEX, 16'hFFFE);
      checkOutput("jmp.opcode", 16'(bus.opcode_IDEX), 16'h0004);
      checkOutput("jmp.pc2", bus.PC2_IDEX, 16'h0010);
      checkOutput("jmp.regWrite", 16'(bus.regWrite_IDEX), 16'h0000);

      // Squash overrides an active stall
      applyStimulus(16'hDB64, 16'h0012, 1'b0);
      setExMem(1'b1, 3'd3);
      #1;
      checkComb("preSq", 1'b1, 1'b0);
      bus.takeBranch_EXMEM = 1'b1;
      #1;
      checkComb("sq", 1'b0, 1'b0);
      tick();
      checkIdex("sq", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00001, 2'b00, 16'h0, 1'b0, 1'b0);
      setExMem(1'b0, 3'd0);
      applyStimulus(16'h27FE, 16'h0014, 1'b0);
      #1;
      checkComb("sqJ", 1'b0, 1'b0);
      tick();
      checkIdex("sqJ", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00001, 2'b00, 16'h0, 1'b0, 1'b0);
      bus.takeBranch_EXMEM = 1'b0;

      // Reset during a stall, then the held instruction decodes against cleared registers
      applyStimulus(16'hDB64, 16'h0016, 1'b0);
      setExMem(1'b1, 3'd3);
      #1;
      checkComb("rstSt", 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      checkIdex("rstSt", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 16'h0, 1'b0, 1'b0);
      rst = 1'b0;
      setExMem(1'b0, 3'd0);
      #1;
      checkComb("postRst", 1'b0, 1'b0);
      tick();
      checkIdex("postRst", 16'h0, 16'h0, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0, 5'b11011, 2'b00, 16'h0016, 1'b0, 1'b0);

      // HALT passes through writing nothing; reset clears it
      applyStimulus(16'h0000, 16'h0020, 1'b1);
      #1;
      checkComb("halt", 1'b0, 1'b0);
      tick();
      checkIdex("halt", 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 16'h0020, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      checkOutput("haltRst.halt", 16'(bus.halt_IDEX), 16'h0000);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
